// File: rtl/sim_pdmem_lat.sv
// Latency-modelling data memory: byte-strobe writes, read-old capture,
// valid/ready request/response with a bounded number of requests in flight.
module sim_pdmem_lat #(
  parameter int DEPTH_WORDS = 2048,
  parameter int LATENCY     = 2,
  parameter int MAX_OUTST   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_we,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          pop;
  logic          req_err;
  logic [29:0]   word;
  logic [AW-1:0] idx;
  logic [31:0]   rd_old;

  logic          pv_q [LATENCY];
  logic [31:0]   pd_q [LATENCY];
  logic          pe_q [LATENCY];

  logic [31:0]   fd_q [MAX_OUTST];
  logic          fe_q [MAX_OUTST];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign word    = i_req_addr[31:2];
  assign idx     = word[AW-1:0];
  assign req_err = (i_req_addr[1:0] != 2'b00)
                || ({2'b00, word} >= 32'(DEPTH_WORDS));
  assign rd_old  = req_err ? 32'h0 : mem[idx];

  assign o_rsp_valid = !i_rst && (fcnt_q != '0);
  assign o_rsp_rdata = o_rsp_valid ? fd_q[rp_q] : 32'h0;
  assign o_rsp_err   = o_rsp_valid ? fe_q[rp_q] : 1'b0;

  assign pop    = o_rsp_valid && i_rsp_ready;
  // a pop frees a slot in the same cycle, so a full memory still streams
  assign o_req_ready = !i_rst
                    && ((cnt_q < CW'(MAX_OUTST)) || pop);
  assign accept = i_req_valid && o_req_ready;
  assign push   = pv_q[LATENCY-1];

  always_ff @(posedge i_clk) begin
    if (accept && i_req_we && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (i_req_wstrb[k]) begin
          mem[idx][8*k +: 8] <= i_req_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= 32'h0;
        pe_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0] <= accept;
      pd_q[0] <= rd_old;
      pe_q[0] <= req_err;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fd_q[wp_q] <= pd_q[LATENCY-1];
      fe_q[wp_q] <= pe_q[LATENCY-1];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      if (push) wp_q <= nxt(wp_q);
      if (pop)  rp_q <= nxt(rp_q);
    end
  end

endmodule
